// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: the redirect-kind
// enum, default parameter values and the next-pc priority decode.
package pc_seq_pkg;

   localparam int          DEFAULT_XLEN       = 32;
   localparam logic [31:0] DEFAULT_RESET_PC   = 32'h3000;
   localparam int          DEFAULT_INSN_BYTES = 4;
   localparam int          DEFAULT_RAS_DEPTH  = 4;

   // Which source feeds the pc register on the next non-stalled edge.
   typedef enum logic [2:0] {
      SEQ,
      BR,
      JMP,
      CALL,
      RET
   } redirect_kind_e;

   // Priority decode: ret > call > jmp > br_taken > sequential.
   // A ret against an empty stack falls back to the sequential path.
   function automatic redirect_kind_e select_kind(
      input logic ret,
      input logic call,
      input logic jmp,
      input logic br_taken,
      input logic stack_empty
   );
      redirect_kind_e kind;
      if (ret) begin
         kind = stack_empty ? SEQ : RET;
      end else if (call) begin
         kind = CALL;
      end else if (jmp) begin
         kind = JMP;
      end else if (br_taken) begin
         kind = BR;
      end else begin
         kind = SEQ;
      end
      return kind;
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Request/status bundle between the fetch controller (master) and the
// pc sequencer (slave).
interface pc_sequencer_if #(
   parameter int XLEN      = 32,
   parameter int RAS_DEPTH = 4
);

   localparam int CNT_W = $clog2(RAS_DEPTH + 1);

   logic             stall;
   logic             br_taken;
   logic [XLEN-1:0]  br_offset;
   logic             jmp;
   logic             call;
   logic             ret;
   logic [XLEN-1:0]  jmp_target;

   logic [XLEN-1:0]  pc;
   logic             pc_valid;
   logic [CNT_W-1:0] ras_count;
   logic             ras_overflow;
   logic             ras_underflow;
   logic             misaligned;

   modport master (
      output stall, br_taken, br_offset, jmp, call, ret, jmp_target,
      input  pc, pc_valid, ras_count, ras_overflow, ras_underflow, misaligned
   );

   modport slave (
      input  stall, br_taken, br_offset, jmp, call, ret, jmp_target,
      output pc, pc_valid, ras_count, ras_overflow, ras_underflow, misaligned
   );

endinterface

// File: rtl/pc_sequencer_ras_stack.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop from an empty stack leaves everything untouched.
// Both conditions raise a registered one-cycle flag.
module ras_stack #(
   parameter int XLEN  = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [XLEN-1:0]            push_data,
   output logic [XLEN-1:0]            top,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [XLEN-1:0]  mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr_inc;
   logic [CNT_W-1:0] count_reg;
   logic             overflow_reg;
   logic             underflow_reg;
   logic             full;
   logic             do_push;

   // Pop wins if both are requested; the top level never asks for both.
   assign do_push    = push && !pop;
   assign full       = (count_reg == FULL_CNT);
   assign empty      = (count_reg == '0);
   assign rd_ptr     = (wr_ptr_reg == '0) ? LAST_PTR : wr_ptr_reg - PTR_W'(1);
   assign wr_ptr_inc = (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);

   assign top       = mem[rd_ptr];
   assign count     = count_reg;
   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;

   // Entry storage: written on push, never cleared (reset only drops pointers).
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer, occupancy and event-flag bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else if (do_push) begin
         wr_ptr_reg    <= wr_ptr_inc;
         count_reg     <= full ? count_reg : count_reg + CNT_W'(1);
         overflow_reg  <= full;
         underflow_reg <= 1'b0;
      end else if (pop) begin
         if (!empty) begin
            wr_ptr_reg <= rd_ptr;
            count_reg  <= count_reg - CNT_W'(1);
         end
         overflow_reg  <= 1'b0;
         underflow_reg <= empty;
      end else begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: a single priority mux chooses among
// sequential, branch, jump, call and return targets and feeds one pc
// register. Calls and returns go through a circular return-address stack.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int              XLEN       = DEFAULT_XLEN,
   parameter logic [XLEN-1:0] RESET_PC   = DEFAULT_RESET_PC,
   parameter int              INSN_BYTES = DEFAULT_INSN_BYTES,
   parameter int              RAS_DEPTH  = DEFAULT_RAS_DEPTH
) (
   input logic             clk,
   input logic             rst,
   pc_sequencer_if.slave   bus
);

   localparam int              CNT_W      = $clog2(RAS_DEPTH + 1);
   localparam logic [XLEN-1:0] STEP       = XLEN'(INSN_BYTES);
   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INSN_BYTES - 1);

   logic [XLEN-1:0]  pc_reg;
   logic [XLEN-1:0]  pc_next;
   logic             pc_valid_reg;
   logic [XLEN-1:0]  seq_pc;
   logic [XLEN-1:0]  br_pc;
   logic [XLEN-1:0]  ras_top;
   logic [CNT_W-1:0] ras_count;
   logic             ras_empty;
   logic             ras_overflow;
   logic             ras_underflow;
   logic             push;
   logic             pop;
   redirect_kind_e   kind;

   // Address arithmetic wraps modulo 2^XLEN by construction.
   assign seq_pc = pc_reg + STEP;
   assign br_pc  = pc_reg + bus.br_offset;

   assign kind = select_kind(bus.ret, bus.call, bus.jmp, bus.br_taken, ras_empty);

   // Stack side effects only for the winning request, and never while stalled.
   // Any ret reaches the stack so that an empty-stack ret can flag underflow.
   assign push = !bus.stall && (kind == CALL);
   assign pop  = !bus.stall && bus.ret;

   // Next-pc priority mux.
   always_comb begin
      pc_next = seq_pc;
      case (kind)
         RET:     pc_next = ras_top;
         CALL:    pc_next = bus.jmp_target;
         JMP:     pc_next = bus.jmp_target;
         BR:      pc_next = br_pc;
         default: pc_next = seq_pc;
      endcase
   end

   // pc register; reset parks one step before RESET_PC so the first
   // sequential advance lands on the first real fetch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_reg       <= RESET_PC - STEP;
         pc_valid_reg <= 1'b0;
      end else if (!bus.stall) begin
         pc_reg       <= pc_next;
         pc_valid_reg <= 1'b1;
      end
   end

   ras_stack #(
      .XLEN  (XLEN),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .pop       (pop),
      .push_data (seq_pc),
      .top       (ras_top),
      .count     (ras_count),
      .empty     (ras_empty),
      .overflow  (ras_overflow),
      .underflow (ras_underflow)
   );

   assign bus.pc            = pc_reg;
   assign bus.pc_valid      = pc_valid_reg;
   assign bus.ras_count     = ras_count;
   assign bus.ras_overflow  = ras_overflow;
   assign bus.ras_underflow = ras_underflow;
   assign bus.misaligned    = |(pc_reg & ALIGN_MASK);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters.
module tb_pc_sequencer;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   pc_sequencer_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

   pc_sequencer #(
      .XLEN       (32),
      .RESET_PC   (32'h3000),
      .INSN_BYTES (4),
      .RAS_DEPTH  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_req();
      bus.stall      = 1'b0;
      bus.br_taken   = 1'b0;
      bus.br_offset  = '0;
      bus.jmp        = 1'b0;
      bus.call       = 1'b0;
      bus.ret        = 1'b0;
      bus.jmp_target = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_state(input string tag, input logic [31:0] pc_exp,
                               input logic [2:0] cnt_exp, input logic ovf_exp,
                               input logic unf_exp);
      check({tag, ".pc"}, bus.pc, pc_exp);
      check({tag, ".cnt"}, bus.ras_count, cnt_exp);
      check({tag, ".ovf"}, bus.ras_overflow, ovf_exp);
      check({tag, ".unf"}, bus.ras_underflow, unf_exp);
      $display("step %-10s pc=%08h cnt=%0d ovf=%0b unf=%0b valid=%0b",
               tag, bus.pc, bus.ras_count, bus.ras_overflow, bus.ras_underflow, bus.pc_valid);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      clear_req();
      rst = 1'b1;
      #1;
      expect_state("reset", 32'h2FFC, 3'd0, 1'b0, 1'b0);
      check("reset.valid", bus.pc_valid, 1'b0);
      check("reset.misal", bus.misaligned, 1'b0);
      #1 rst = 1'b0;

      // Sequential start-up
      step(); expect_state("seq0", 32'h3000, 3'd0, 1'b0, 1'b0);
      check("seq0.valid", bus.pc_valid, 1'b1);
      step(); expect_state("seq1", 32'h3004, 3'd0, 1'b0, 1'b0);
      step(); expect_state("seq2", 32'h3008, 3'd0, 1'b0, 1'b0);

      // Backward branch
      bus.br_taken = 1'b1; bus.br_offset = 32'hFFFF_FFF8;
      step(); expect_state("br_back", 32'h3000, 3'd0, 1'b0, 1'b0);
      clear_req();

      // Wrap-around at top of address space
      bus.jmp = 1'b1; bus.jmp_target = 32'hFFFF_FFFC;
      step(); expect_state("jmp_top", 32'hFFFF_FFFC, 3'd0, 1'b0, 1'b0);
      clear_req();
      step(); expect_state("wrap", 32'h0000_0000, 3'd0, 1'b0, 1'b0);

      // Misalignment flag
      bus.jmp = 1'b1; bus.jmp_target = 32'h4002;
      step(); expect_state("jmp_mis", 32'h4002, 3'd0, 1'b0, 1'b0);
      check("jmp_mis.misal", bus.misaligned, 1'b1);
      bus.jmp_target = 32'h3010;
      step(); expect_state("jmp3010", 32'h3010, 3'd0, 1'b0, 1'b0);
      check("jmp3010.misal", bus.misaligned, 1'b0);
      clear_req();

      // Call / return pair
      bus.call = 1'b1; bus.jmp_target = 32'h4000;
      step(); expect_state("call4000", 32'h4000, 3'd1, 1'b0, 1'b0);
      clear_req();
      step(); expect_state("seq4004", 32'h4004, 3'd1, 1'b0, 1'b0);
      step(); expect_state("seq4008", 32'h4008, 3'd1, 1'b0, 1'b0);
      bus.ret = 1'b1;
      step(); expect_state("ret3014", 32'h3014, 3'd0, 1'b0, 1'b0);
      clear_req();

      // Five nested calls into a 4-deep stack
      bus.call = 1'b1;
      bus.jmp_target = 32'h5000; step(); expect_state("call1", 32'h5000, 3'd1, 1'b0, 1'b0);
      bus.jmp_target = 32'h6000; step(); expect_state("call2", 32'h6000, 3'd2, 1'b0, 1'b0);
      bus.jmp_target = 32'h7000; step(); expect_state("call3", 32'h7000, 3'd3, 1'b0, 1'b0);
      bus.jmp_target = 32'h8000; step(); expect_state("call4", 32'h8000, 3'd4, 1'b0, 1'b0);
      bus.jmp_target = 32'h9000; step(); expect_state("call5", 32'h9000, 3'd4, 1'b1, 1'b0);
      clear_req();
      bus.ret = 1'b1;
      step(); expect_state("ret1", 32'h8004, 3'd3, 1'b0, 1'b0);
      step(); expect_state("ret2", 32'h7004, 3'd2, 1'b0, 1'b0);
      step(); expect_state("ret3", 32'h6004, 3'd1, 1'b0, 1'b0);
      step(); expect_state("ret4", 32'h5004, 3'd0, 1'b0, 1'b0);
      step(); expect_state("ret5", 32'h5008, 3'd0, 1'b0, 1'b1);
      clear_req();
      step(); expect_state("post_unf", 32'h500C, 3'd0, 1'b0, 1'b0);

      // Stall with every redirect asserted
      bus.call = 1'b1; bus.jmp_target = 32'hB000;
      step(); expect_state("callB000", 32'hB000, 3'd1, 1'b0, 1'b0);
      bus.stall = 1'b1; bus.jmp = 1'b1; bus.ret = 1'b1; bus.br_taken = 1'b1;
      bus.br_offset = 32'h40; bus.jmp_target = 32'hA000;
      for (int i = 0; i < 3; i++) begin
         step(); expect_state("stall", 32'hB000, 3'd1, 1'b0, 1'b0);
         check("stall.valid", bus.pc_valid, 1'b1);
      end
      clear_req();
      step(); expect_state("unstall", 32'hB004, 3'd1, 1'b0, 1'b0);

      // call + jmp + br together: call wins
      bus.call = 1'b1; bus.jmp = 1'b1; bus.br_taken = 1'b1;
      bus.br_offset = 32'h100; bus.jmp_target = 32'hC000;
      step(); expect_state("call_win", 32'hC000, 3'd2, 1'b0, 1'b0);
      clear_req();

      // ret + call together: ret wins, no push
      bus.ret = 1'b1; bus.call = 1'b1; bus.jmp_target = 32'hE000;
      step(); expect_state("ret_win", 32'hB008, 3'd1, 1'b0, 1'b0);
      clear_req();
      bus.call = 1'b1; bus.jmp_target = 32'hD000;
      step(); expect_state("callD000", 32'hD000, 3'd2, 1'b0, 1'b0);
      clear_req();

      // Asynchronous reset between clock edges
      #2 rst = 1'b1;
      #1;
      expect_state("async_rst", 32'h2FFC, 3'd0, 1'b0, 1'b0);
      check("async_rst.valid", bus.pc_valid, 1'b0);
      #1 rst = 1'b0;
      bus.ret = 1'b1;
      step(); expect_state("ret_empty", 32'h3000, 3'd0, 1'b0, 1'b1);
      check("ret_empty.valid", bus.pc_valid, 1'b1);
      clear_req();
      step(); expect_state("final_seq", 32'h3004, 3'd0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter XLEN, default 32, width of PC and all address/offset ports.
REQ-002 Parameter RESET_PC, default 32'h3000, address of the first valid fetch.
REQ-003 Parameter INSN_BYTES, default 4, sequential increment; power of two.
REQ-004 Parameter RAS_DEPTH, default 4, return-address-stack entries; at least 1.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 stall  input  1  hold PC and stack this cycle.
REQ-008 br_taken  input  1  conditional branch taken.
REQ-009 br_offset  input  XLEN  branch offset, relative to current pc.
REQ-010 jmp  input  1  absolute jump to jmp_target.
REQ-011 call  input  1  push return address, then jump to jmp_target.
REQ-012 ret  input  1  pop return address into pc.
REQ-013 jmp_target  input  XLEN  absolute target for jmp and call.
REQ-014 pc  output  XLEN  current fetch address, registered.
REQ-015 pc_valid  output  1  pc holds a real fetch address.
REQ-016 ras_count  output  $clog2(RAS_DEPTH+1)  number of valid stack entries.
REQ-017 ras_overflow  output  1  one-cycle pulse: push while stack full.
REQ-018 ras_underflow  output  1  one-cycle pulse: ret while stack empty.
REQ-019 misaligned  output  1  pc low log2(INSN_BYTES) bits nonzero, combinational from pc.

Function
REQ-020 Per non-stalled edge, next-pc priority SHALL be: ret > call > jmp > br_taken > sequential.
REQ-021 Sequential: pc <= pc + INSN_BYTES.
REQ-022 Branch: pc <= pc + br_offset.
REQ-023 Jump: pc <= jmp_target.
REQ-024 Call: push pc + INSN_BYTES, then pc <= jmp_target.
REQ-025 Ret, stack non-empty: pc <= top entry; pop.
REQ-026 All address arithmetic SHALL be modulo 2^XLEN; wrap-around is silent.
REQ-027 Push when ras_count == RAS_DEPTH SHALL overwrite the oldest entry (circular), keep count at RAS_DEPTH, and pulse ras_overflow.
REQ-028 Ret when ras_count == 0 SHALL take the sequential path, leave the stack unchanged, and pulse ras_underflow.
REQ-029 A lower-priority request asserted together with a higher-priority one SHALL be ignored; it has no stack side effect.
REQ-030 With stall high, pc, pc_valid, and the stack SHALL hold; ras_overflow and ras_underflow SHALL be 0; redirect inputs SHALL be ignored.
REQ-031 pc_valid SHALL go to 1 on the first non-stalled edge after reset and stay 1 until the next reset.
REQ-032 ras_overflow and ras_underflow SHALL be registered, each high for exactly one cycle per event.

Reset
REQ-033 rst high SHALL asynchronously set pc = RESET_PC - INSN_BYTES, pc_valid = 0, ras_count = 0, ras_overflow = 0, ras_underflow = 0.
REQ-034 Reset mid-operation SHALL discard all stack contents; no entry survives.
REQ-035 Stack entry storage need not be cleared; only the pointers and count are reset.

Structure
REQ-036 Shared package pc_seq_pkg SHALL hold the redirect-kind enum (SEQ, BR, JMP, CALL, RET) and the default parameter constants.
REQ-037 The stack SHALL be one sub-module, ras_stack: circular LIFO with push, pop, top, count, overflow, and underflow.
REQ-038 Next-pc selection SHALL be a single combinational priority mux feeding one pc register.

Verification
REQ-039 Reset release, no stall: pc sequence 0x2FFC (pc_valid=0), then 0x3000, 0x3004, 0x3008 with pc_valid=1.
REQ-040 At pc=0x3008, br_taken with br_offset=0xFFFFFFF8 -> pc=0x3000; at pc=0xFFFFFFFC sequential -> pc=0x00000000.
REQ-041 call to 0x4000 at pc=0x3010, then ret at 0x4008 -> pc 0x4000, 0x4004, 0x4008, 0x3014; ras_count 1 then 0.
REQ-042 RAS_DEPTH=4: five nested calls -> ras_overflow pulses once on the fifth; five rets return the four newest addresses, then the fifth ret pulses ras_underflow and pc advances by 4.
REQ-043 stall held 3 cycles with call, jmp, and ret asserted -> pc, ras_count, and pulse outputs unchanged; call+jmp+br in one cycle -> call wins.
REQ-044 rst asserted asynchronously mid-cycle with ras_count=2 -> pc=0x2FFC and ras_count=0 immediately, without a clock edge; a following ret pulses ras_underflow.
